reduce_feeder: RTL and testbench

Input staging stage that sits directly upstream of the `reduce_sum` accumulator. It accepts a bursty ready/valid sample stream into a small FIFO and replays it as a paced valid-only stream. The replayed stream is framed into blocks of `BLOCK_LEN` beats, and a programmable idle gap follows every block so the downstream reducer's result can be collected. The downstream port has no backpressure, which matches the reducer's `in_data`/`in_valid` input.

---
 rtl/reduce_pkg.sv | 8 +
 rtl/reduce_feeder_if.sv | 27 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/reduce_feeder.sv | 127 ++++++++++++
 tb/tb_reduce_feeder.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reduce_pkg.sv
// Shared constants and types for the reduce_sum datapath and its input feeder.
package reduce_pkg;
    localparam int DATA_W_DEF    = 32;
    localparam int BUFFER_DEPTH  = 256;
    localparam int BLOCK_LEN_DEF = BUFFER_DEPTH;

    typedef enum logic [0:0] {ST_STREAM, ST_GAP} feeder_state_t;
endpackage

// File: rtl/reduce_feeder_if.sv
// Upstream ready/valid port, downstream valid-only port and status of reduce_feeder.
interface reduce_feeder_if
    import reduce_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LVL_W  = 5
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              flush;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic [15:0]       frame_cnt;
    logic [LVL_W-1:0]  fifo_level;

    modport slave (
        input  s_data, s_valid, flush,
        output s_ready, m_data, m_valid, m_last, frame_cnt, fifo_level
    );

    modport master (
        output s_data, s_valid, flush,
        input  s_ready, m_data, m_valid, m_last, frame_cnt, fifo_level
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; read data is the head entry (show-ahead).
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              do_wr, do_rd;

    assign level   = wptr_q - rptr_q;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full && !clear;
    assign do_rd   = rd_en && !empty && !clear;
    assign rd_data = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_wr) wptr_d = wptr_q + 1'b1;
            if (do_rd) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/reduce_feeder.sv
// Buffers a bursty sample stream and replays it as BLOCK_LEN-beat frames
// separated by GAP_CYCLES idle cycles, feeding reduce_sum without backpressure.
module reduce_feeder
    import reduce_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int BLOCK_LEN  = BLOCK_LEN_DEF,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    reduce_feeder_if.slave bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BW    = $clog2(BLOCK_LEN);
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    feeder_state_t     state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              pop, pop_last;
    logic              s_ready;

    logic [DATA_W-1:0] rd_data;
    logic [LVL_W-1:0]  level;
    logic              full, empty;

    // bit 0: popped entry staged, bit 1: beat on the output port
    logic [1:0]        vld_pipe_q, last_pipe_q;
    logic [DATA_W-1:0] s1_data_q, m_data_q;
    logic [15:0]       frame_cnt_q;

    assign s_ready = rst_n && !full && !bus.flush;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (bus.flush),
        .wr_en   (bus.s_valid && s_ready),
        .wr_data (bus.s_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        pop      = 1'b0;
        pop_last = 1'b0;
        if (bus.flush) begin
            state_d = ST_STREAM;
            beat_d  = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                ST_STREAM: begin
                    if (!empty) begin
                        pop = 1'b1;
                        if (beat_q == BW'(BLOCK_LEN - 1)) begin
                            pop_last = 1'b1;
                            beat_d   = '0;
                            if (GAP_CYCLES > 0) begin
                                state_d = ST_GAP;
                                gap_d   = '0;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        state_d = ST_STREAM;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = ST_STREAM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STREAM;
            beat_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
        end
    end

    // Frame count advances on the edge that puts the last beat on the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            s1_data_q   <= '0;
            m_data_q    <= '0;
            frame_cnt_q <= '0;
        end else if (bus.flush) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[0], pop};
            last_pipe_q <= {last_pipe_q[0], pop_last};
            if (pop) s1_data_q <= rd_data;
            if (vld_pipe_q[0]) m_data_q <= s1_data_q;
            if (vld_pipe_q[0] && last_pipe_q[0]) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.m_data     = m_data_q;
    assign bus.m_valid    = vld_pipe_q[1];
    assign bus.m_last     = last_pipe_q[1];
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.fifo_level = level;
endmodule

// File: tb/tb_reduce_feeder.sv
// Scoreboard bench for reduce_feeder: three instances cover the gap, backpressure
// and no-gap configurations, all with 4-beat frames.
module tb_reduce_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reduce_feeder_if #(.DATA_W(32), .LVL_W(3)) ifa ();
  reduce_feeder_if #(.DATA_W(32), .LVL_W(3)) ifb ();
  reduce_feeder_if #(.DATA_W(32), .LVL_W(5)) ifc ();

  reduce_feeder #(.DATA_W(32), .FIFO_DEPTH(4),  .BLOCK_LEN(4), .GAP_CYCLES(2))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  reduce_feeder #(.DATA_W(32), .FIFO_DEPTH(4),  .BLOCK_LEN(4), .GAP_CYCLES(8))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  reduce_feeder #(.DATA_W(32), .FIFO_DEPTH(16), .BLOCK_LEN(4), .GAP_CYCLES(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] qa[$], qb[$], qc[$];
  int bt[3];
  logic [31:0] o_data;
  logic        o_valid, o_last, o_ready, acc;
  logic [15:0] o_frame;
  logic [7:0]  o_level;

  task automatic sb_clear();
    qa.delete(); qb.delete(); qc.delete();
    bt = '{0, 0, 0};
  endtask

  // One cycle: sample the selected instance, score any beat, then drive its inputs.
  task automatic step(input int sel, input logic v, input logic [31:0] d, input logic fl);
    logic [31:0] exp;
    int n;
    logic rdy;
    @(negedge clk);
    cyc++;
    case (sel)
      0: begin o_data = ifa.m_data; o_valid = ifa.m_valid; o_last = ifa.m_last;
               o_frame = ifa.frame_cnt; o_level = 8'(ifa.fifo_level); o_ready = ifa.s_ready; n = qa.size(); end
      1: begin o_data = ifb.m_data; o_valid = ifb.m_valid; o_last = ifb.m_last;
               o_frame = ifb.frame_cnt; o_level = 8'(ifb.fifo_level); o_ready = ifb.s_ready; n = qb.size(); end
      default: begin o_data = ifc.m_data; o_valid = ifc.m_valid; o_last = ifc.m_last;
               o_frame = ifc.frame_cnt; o_level = 8'(ifc.fifo_level); o_ready = ifc.s_ready; n = qc.size(); end
    endcase
    if (o_valid) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL sb_extra[%0d] got beat data=%0h, required no beat", sel, o_data);
      end else begin
        case (sel)
          0: exp = qa.pop_front();
          1: exp = qb.pop_front();
          default: exp = qc.pop_front();
        endcase
        if (o_data !== exp) begin
          errors++;
          $display("FAIL sb_data[%0d] got=%0h exp=%0h", sel, o_data, exp);
        end
      end
      checks++;
      if (o_last !== (bt[sel] == 3)) begin
        errors++;
        $display("FAIL sb_last[%0d] got=%0b exp=%0b", sel, o_last, (bt[sel] == 3));
      end
      bt[sel] = (bt[sel] + 1) % 4;
    end else begin
      checks++;
      if (o_last !== 1'b0) begin
        errors++;
        $display("FAIL last_idle[%0d] got=%0b exp=0", sel, o_last);
      end
    end
    case (sel)
      0: begin ifa.s_valid = v; ifa.s_data = d; ifa.flush = fl; end
      1: begin ifb.s_valid = v; ifb.s_data = d; ifb.flush = fl; end
      default: begin ifc.s_valid = v; ifc.s_data = d; ifc.flush = fl; end
    endcase
    if (fl) begin
      case (sel)
        0: qa.delete();
        1: qb.delete();
        default: qc.delete();
      endcase
      bt[sel] = 0;
    end
    #1;
    case (sel)
      0: rdy = ifa.s_ready;
      1: rdy = ifb.s_ready;
      default: rdy = ifc.s_ready;
    endcase
    acc = v && rdy;
    if (acc) begin
      case (sel)
        0: qa.push_back(d);
        1: qb.push_back(d);
        default: qc.push_back(d);
      endcase
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ifa.m_valid, ifa.m_last, ifa.s_ready} !== 3'b000 || ifa.m_data !== 32'd0 ||
        ifa.frame_cnt !== 16'd0 || ifa.fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold got v=%0b l=%0b rdy=%0b d=%0h f=%0h lvl=%0d exp all 0",
               ifa.m_valid, ifa.m_last, ifa.s_ready, ifa.m_data, ifa.frame_cnt, ifa.fifo_level);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b0, 32'd0, 1'b0);
    checks++;
    if (o_ready !== 1'b1 || o_level !== 8'd0 || o_valid !== 1'b0 || o_frame !== 16'd0) begin
      errors++;
      $display("FAIL reset_release got rdy=%0b lvl=%0d v=%0b f=%0d exp 1/0/0/0", o_ready, o_level, o_valid, o_frame);
    end
  endtask

  task automatic test_basic();
    int vc[$];
    logic [15:0] fr[$];
    int first_acc = -1;
    for (int i = 0; i < 28; i++) begin
      step(0, i < 8, 32'(i), 1'b0);
      if (acc && first_acc < 0) first_acc = cyc;
      if (o_valid) begin vc.push_back(cyc); fr.push_back(o_frame); end
    end
    checks++;
    if (vc.size() != 8) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=8", vc.size());
    end else begin
      checks++;
      if (vc[0] - first_acc != 3) begin
        errors++; $display("FAIL basic_latency got=%0d exp=3 (sample steps)", vc[0] - first_acc);
      end
      checks++;
      if (vc[3] - vc[0] != 3) begin
        errors++; $display("FAIL basic_contig got=%0d exp=3", vc[3] - vc[0]);
      end
      checks++;
      if (fr[2] !== 16'd0 || fr[3] !== 16'd1) begin
        errors++; $display("FAIL basic_frame got=%0d,%0d exp=0,1", fr[2], fr[3]);
      end
      checks++;
      if (vc[4] - vc[3] - 1 != 2) begin
        errors++; $display("FAIL basic_gap got=%0d exp=2", vc[4] - vc[3] - 1);
      end
      checks++;
      if (fr[7] !== 16'd2) begin
        errors++; $display("FAIL basic_frame2 got=%0d exp=2", fr[7]);
      end
    end
  endtask

  task automatic test_backpressure();
    int vc[$];
    int sent = 0;
    int budget = 0;
    bit saw_full = 0;
    bit bad = 0;
    while (sent < 12 && budget < 200) begin
      step(1, 1'b1, 32'(sent), 1'b0);
      budget++;
      if (o_level == 8'd4 && !o_ready) saw_full = 1;
      if (o_level == 8'd4 && o_ready) bad = 1;
      if (o_valid) vc.push_back(cyc);
      if (acc) sent++;
    end
    checks++;
    if (sent != 12) begin errors++; $display("FAIL bp_timeout got=%0d exp=12 sent", sent); end
    for (int i = 0; i < 40; i++) begin
      step(1, 1'b0, 32'd0, 1'b0);
      if (o_valid) vc.push_back(cyc);
    end
    checks++;
    if (!saw_full) begin errors++; $display("FAIL bp_full got=0 exp=1 (ready low at level 4)"); end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_ready_full got=1 exp=0 (ready high at level 4)"); end
    checks++;
    if (vc.size() != 12 || qb.size() != 0) begin
      errors++; $display("FAIL bp_count got=%0d left=%0d exp=12 left=0", vc.size(), qb.size());
    end else begin
      checks++;
      if (vc[4] - vc[3] - 1 != 8 || vc[8] - vc[7] - 1 != 8) begin
        errors++; $display("FAIL bp_gap got=%0d,%0d exp=8,8", vc[4] - vc[3] - 1, vc[8] - vc[7] - 1);
      end
    end
  endtask

  task automatic test_flush();
    int vc[$];
    logic [15:0] fr_before;
    int beats = 0;
    int budget = 0;
    int k = 0;
    int last_idx = -1;
    logic [15:0] fr_last = 16'hDEAD;
    step(0, 1'b0, 32'd0, 1'b0);
    fr_before = o_frame;
    while (beats < 2 && budget < 30) begin
      step(0, 1'b1, 32'(100 + k), 1'b0);
      if (acc) k++;
      if (o_valid) beats++;
      budget++;
    end
    checks++;
    if (beats != 2) begin errors++; $display("FAIL flush_timeout got=%0d exp=2 beats", beats); end
    step(0, 1'b0, 32'd0, 1'b1);
    step(0, 1'b0, 32'd0, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_level !== 8'd0) begin
      errors++; $display("FAIL flush_clear got v=%0b lvl=%0d exp v=0 lvl=0", o_valid, o_level);
    end
    checks++;
    if (o_frame !== fr_before) begin
      errors++; $display("FAIL flush_frame got=%0d exp=%0d", o_frame, fr_before);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, i < 4, 32'(200 + i), 1'b0);
      if (o_valid) begin
        if (o_last) begin last_idx = vc.size(); fr_last = o_frame; end
        vc.push_back(cyc);
      end
    end
    checks++;
    if (vc.size() != 4 || last_idx != 3 || fr_last !== fr_before + 16'd1) begin
      errors++; $display("FAIL flush_fresh got n=%0d last=%0d f=%0d exp n=4 last=3 f=%0d",
                         vc.size(), last_idx, fr_last, fr_before + 16'd1);
    end
  endtask

  task automatic test_async_reset();
    int beats = 0;
    int budget = 0;
    int k = 0;
    int n = 0;
    int last_idx = -1;
    logic [15:0] fr_last = 16'hDEAD;
    while (beats < 2 && budget < 30) begin
      step(0, 1'b1, 32'(300 + k), 1'b0);
      if (acc) k++;
      if (o_valid) beats++;
      budget++;
    end
    checks++;
    if (beats != 2) begin errors++; $display("FAIL arst_timeout got=%0d exp=2 beats", beats); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.m_valid !== 1'b0 || ifa.m_last !== 1'b0 || ifa.m_data !== 32'd0) begin
      errors++; $display("FAIL arst_port got v=%0b l=%0b d=%0h exp 0/0/0", ifa.m_valid, ifa.m_last, ifa.m_data);
    end
    checks++;
    if (ifa.frame_cnt !== 16'd0 || ifa.fifo_level !== 3'd0 || ifa.s_ready !== 1'b0) begin
      errors++; $display("FAIL arst_status got f=%0d lvl=%0d rdy=%0b exp 0/0/0", ifa.frame_cnt, ifa.fifo_level, ifa.s_ready);
    end
    ifa.s_valid = 1'b0;
    sb_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(0, i < 4, 32'(400 + i), 1'b0);
      if (o_valid) begin
        if (o_last) begin last_idx = n; fr_last = o_frame; end
        n++;
      end
    end
    checks++;
    if (n != 4 || last_idx != 3 || fr_last !== 16'd1) begin
      errors++; $display("FAIL arst_frame got n=%0d last=%0d f=%0d exp n=4 last=3 f=1", n, last_idx, fr_last);
    end
  endtask

  task automatic test_back_to_back();
    int vc[$];
    logic [11:0] lastmask = '0;
    for (int i = 0; i < 30; i++) begin
      step(2, i < 12, 32'(32'hA0 + i), 1'b0);
      if (o_valid) begin
        if (o_last && vc.size() < 12) lastmask[vc.size()] = 1'b1;
        vc.push_back(cyc);
      end
    end
    checks++;
    if (vc.size() != 12) begin
      errors++; $display("FAIL b2b_count got=%0d exp=12", vc.size());
    end else begin
      checks++;
      if (vc[11] - vc[0] != 11) begin
        errors++; $display("FAIL b2b_contig got=%0d exp=11", vc[11] - vc[0]);
      end
    end
    checks++;
    if (lastmask !== 12'h888) begin
      errors++; $display("FAIL b2b_lastpos got=%03h exp=888", lastmask);
    end
    checks++;
    if (o_frame !== 16'd3) begin
      errors++; $display("FAIL b2b_frames got=%0d exp=3", o_frame);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    logic [15:0] fr_last = 16'hDEAD;
    step(0, 1'b0, 32'd0, 1'b0);
    force dut_a.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_a.frame_cnt_q;
    step(0, 1'b0, 32'd0, 1'b0);
    checks++;
    if (o_frame !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preset got=%04h exp=ffff", o_frame);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, i < 4, 32'(500 + i), 1'b0);
      if (o_valid) begin
        if (o_last) fr_last = o_frame;
        n++;
      end
    end
    checks++;
    if (n != 4 || fr_last !== 16'h0000) begin
      errors++; $display("FAIL wrap_frame got n=%0d f=%04h exp n=4 f=0000", n, fr_last);
    end
  endtask

  initial begin
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.flush = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.flush = 1'b0;
    ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.flush = 1'b0;
    sb_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
